// File: rtl/vga_scanout.sv
// vga_scanout: VGA timing generator and frame-buffer scanout; define VGA_PAGE_FLIP_EN for two-page flipping
module vga_scanout #(
    parameter int    H_LINE        = 640,
    parameter int    H_FRONT_PORCH = 16,
    parameter int    H_SYNC_PULSE  = 96,
    parameter int    H_BACK_PORCH  = 48,
    parameter int    V_LINE        = 480,
    parameter int    V_FRONT_PORCH = 10,
    parameter int    V_SYNC_PULSE  = 2,
    parameter int    V_BACK_PORCH  = 33,
    parameter int    H_SCALE       = 1,
    parameter int    V_SCALE       = 1,
    parameter string PIXEL_FORMAT  = "rgb332",
    parameter int    RD_LATENCY    = 1,
    localparam int   DEPTH         = (PIXEL_FORMAT == "rgb12") ? 12 : 8,
    localparam int   PW            = H_LINE / H_SCALE,
    localparam int   PH            = V_LINE / V_SCALE,
    localparam int   PAGE          = PW * PH,
`ifdef VGA_PAGE_FLIP_EN
    localparam int   ADDR_W        = $clog2(2 * PAGE)
`else
    localparam int   ADDR_W        = $clog2(PAGE)
`endif
) (
    input  logic              pxclk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              page_sel,
    output logic              fb_rd,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [DEPTH-1:0]  fb_data,
    output logic [3:0]        r,
    output logic [3:0]        g,
    output logic [3:0]        b,
    output logic              hsync,
    output logic              vsync,
    output logic              page_active,
    output logic              frame_start
);
    localparam int H_TOTAL = H_LINE + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
    localparam int V_TOTAL = V_LINE + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int HSW     = $clog2(H_SCALE + 1);
    localparam int VSW     = $clog2(V_SCALE + 1);
    localparam int PL      = RD_LATENCY + 1;

    if (PIXEL_FORMAT != "rgb332" && PIXEL_FORMAT != "rgb12") begin : g_bad_fmt
        $error("vga_scanout: unsupported PIXEL_FORMAT %s", PIXEL_FORMAT);
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_lat
        $error("vga_scanout: RD_LATENCY must be 1..4");
    end

    logic [HW-1:0]         h_cnt;
    logic [VW-1:0]         v_cnt;
    logic [HSW-1:0]        h_rep;
    logic [VSW-1:0]        v_rep;
    logic [ADDR_W-1:0]     col;
    logic [ADDR_W-1:0]     row_base;
    logic [ADDR_W-1:0]     page_base;
    logic [RD_LATENCY-1:0] rd_d;
    logic [PL-1:0]         hs_d;
    logic [PL-1:0]         vs_d;
    logic [11:0]           px;
    logic                  h_end, v_end, h_vis, v_vis, hs_raw, vs_raw, h_step, v_step;

    assign h_end  = h_cnt == HW'(H_TOTAL - 1);
    assign v_end  = v_cnt == VW'(V_TOTAL - 1);
    assign h_vis  = h_cnt < HW'(H_LINE);
    assign v_vis  = v_cnt < VW'(V_LINE);
    assign h_step = h_rep == HSW'(H_SCALE - 1);
    assign v_step = v_rep == VSW'(V_SCALE - 1);
    assign hs_raw = h_cnt >= HW'(H_LINE + H_FRONT_PORCH) && h_cnt <= HW'(H_LINE + H_FRONT_PORCH + H_SYNC_PULSE - 1);
    assign vs_raw = v_cnt >= VW'(V_LINE + V_FRONT_PORCH) && v_cnt <= VW'(V_LINE + V_FRONT_PORCH + V_SYNC_PULSE - 1);

    assign fb_rd       = h_vis && v_vis && enable;
    assign fb_addr     = fb_rd ? page_base + row_base + col : '0;
    assign frame_start = h_cnt == '0 && v_cnt == '0;
    assign hsync       = hs_d[RD_LATENCY];
    assign vsync       = vs_d[RD_LATENCY];

    if (DEPTH == 12) begin : g_rgb12
        assign px = fb_data;
    end else begin : g_rgb332
        assign px = {fb_data[7:5], fb_data[7], fb_data[4:2], fb_data[4], fb_data[1:0], fb_data[1:0]};
    end

`ifdef VGA_PAGE_FLIP_EN
    assign page_base = page_active ? ADDR_W'(PAGE) : '0;
    always_ff @(posedge pxclk) begin
        if (!rst_n)
            page_active <= 1'b0;
        else if (h_end && v_end)
            page_active <= page_sel;
    end
`else
    logic unused_page_sel;
    assign unused_page_sel = page_sel;
    assign page_active     = 1'b0;
    assign page_base       = '0;
`endif

    always_ff @(posedge pxclk) begin
        if (!rst_n) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            h_rep    <= '0;
            v_rep    <= '0;
            col      <= '0;
            row_base <= '0;
            rd_d     <= '0;
            hs_d     <= '0;
            vs_d     <= '0;
            r        <= '0;
            g        <= '0;
            b        <= '0;
        end else begin
            h_cnt <= h_end ? '0 : h_cnt + 1'b1;
            if (h_end)
                v_cnt <= v_end ? '0 : v_cnt + 1'b1;
            if (h_end) begin
                h_rep <= '0;
                col   <= '0;
            end else if (h_vis) begin
                h_rep <= h_step ? '0 : h_rep + 1'b1;
                col   <= h_step ? col + 1'b1 : col;
            end
            if (h_end && v_end) begin
                v_rep    <= '0;
                row_base <= '0;
            end else if (h_end && v_vis) begin
                v_rep    <= v_step ? '0 : v_rep + 1'b1;
                row_base <= v_step ? row_base + ADDR_W'(PW) : row_base;
            end
            rd_d      <= (rd_d << 1) | RD_LATENCY'(fb_rd);
            hs_d      <= (hs_d << 1) | PL'(hs_raw);
            vs_d      <= (vs_d << 1) | PL'(vs_raw);
            {r, g, b} <= rd_d[RD_LATENCY-1] ? px : 12'h000;
        end
    end
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: scoreboard bench for vga_scanout on a 16x7 timing with 2x2 replication and read latency 2
module tb_vga_scanout;
`ifdef VGA_PAGE_FLIP_EN
    localparam int AW = 4;
`else
    localparam int AW = 3;
`endif

    typedef struct {
        int          c;
        int          h;
        int          v;
        logic        rd;
        logic [AW-1:0] addr;
        logic        fs;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
        logic        pg;
    } exp_t;

    logic          pxclk = 1'b0;
    logic          rst_n, enable, page_sel;
    logic          fb_rd, hsync, vsync, page_active, frame_start;
    logic [AW-1:0] fb_addr;
    logic [7:0]    fb_data = 8'hFF;
    logic [3:0]    r, g, b;

    exp_t          q[$];
    logic [7:0]    pat [16];
    logic          rd_h [1024];
    logic [AW-1:0] ad_h [1024];
    int            c, checks, errors;
    logic          exp_pg;
    logic          d1_rd = 1'b0, d2_rd = 1'b0;
    logic [AW-1:0] d1_a = '0, d2_a = '0;

    always #5 pxclk = ~pxclk;

    vga_scanout #(
        .H_LINE(8), .H_FRONT_PORCH(2), .H_SYNC_PULSE(3), .H_BACK_PORCH(3),
        .V_LINE(4), .V_FRONT_PORCH(1), .V_SYNC_PULSE(1), .V_BACK_PORCH(1),
        .H_SCALE(2), .V_SCALE(2), .PIXEL_FORMAT("rgb332"), .RD_LATENCY(2)
    ) dut (
        .pxclk(pxclk), .rst_n(rst_n), .enable(enable), .page_sel(page_sel),
        .fb_rd(fb_rd), .fb_addr(fb_addr), .fb_data(fb_data),
        .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync),
        .page_active(page_active), .frame_start(frame_start)
    );

    function automatic logic [11:0] dec(input logic [7:0] d);
        return {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
    endfunction

    always @(negedge pxclk) begin
        fb_data = d2_rd ? pat[d2_a] : 8'hFF;
        d2_rd   = d1_rd;
        d2_a    = d1_a;
        d1_rd   = fb_rd === 1'b1;
        d1_a    = fb_addr;
    end

    task automatic chk(input string n, input exp_t e, input logic [11:0] got, input logic [11:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s c=%0d h=%0d v=%0d got=%0h exp=%0h", n, e.c, e.h, e.v, got, want);
        end
    endtask

    always @(negedge pxclk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("fb_rd", e, 12'(fb_rd), 12'(e.rd));
            chk("fb_addr", e, 12'(fb_addr), 12'(e.addr));
            chk("frame_start", e, 12'(frame_start), 12'(e.fs));
            chk("hsync", e, 12'(hsync), 12'(e.hs));
            chk("vsync", e, 12'(vsync), 12'(e.vs));
            chk("rgb", e, {r, g, b}, e.rgb);
            chk("page_active", e, 12'(page_active), 12'(e.pg));
        end
    end

    task automatic cycle(input logic en, input logic ps);
        exp_t e;
        int h = c % 16;
        int v = (c / 16) % 7;
        int k = c - 3;
        enable   = en;
        page_sel = ps;
        rd_h[c]  = (h < 8) && (v < 4) && en;
        ad_h[c]  = rd_h[c] ? AW'(int'(exp_pg) * 8 + (v / 2) * 4 + h / 2) : '0;
        e.c    = c;
        e.h    = h;
        e.v    = v;
        e.rd   = rd_h[c];
        e.addr = ad_h[c];
        e.fs   = (h == 0) && (v == 0);
        e.pg   = exp_pg;
        if (k < 0) begin
            e.hs  = 1'b0;
            e.vs  = 1'b0;
            e.rgb = 12'h000;
        end else begin
            e.hs  = (k % 16) >= 10 && (k % 16) <= 12;
            e.vs  = ((k / 16) % 7) == 5;
            e.rgb = rd_h[k] ? dec(pat[ad_h[k]]) : 12'h000;
        end
        q.push_back(e);
        @(posedge pxclk);
        #1;
`ifdef VGA_PAGE_FLIP_EN
        if (h == 15 && v == 6)
            exp_pg = ps;
`endif
        c++;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++)
            pat[i] = 8'(8'h25 + i * 8'h1D);
        pat[0]   = 8'hE3;
        rst_n    = 1'b0;
        enable   = 1'b1;
        page_sel = 1'b0;
        c        = 0;
        exp_pg   = 1'b0;
        checks   = 0;
        errors   = 0;
        repeat (3) @(posedge pxclk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 112; i++)
            cycle(1'b1, i >= 16);
        for (int i = 0; i < 112; i++)
            cycle(!(i >= 20 && i < 32), 1'b0);
        for (int i = 0; i < 37; i++)
            cycle(1'b1, 1'b1);
        rst_n = 1'b0;
        cycle(1'b1, 1'b1);
        rst_n  = 1'b1;
        c      = 0;
        exp_pg = 1'b0;
        for (int i = 0; i < 40; i++)
            cycle(1'b1, 1'b0);
        for (int i = 0; i < 4 && q.size() > 0; i++)
            @(negedge pxclk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
